// File: rtl/alu_unit.sv
// Registered RV64I-style integer ALU: add/sub, shifts, set-less-than and bitwise logic,
// selected by {funct7[5], funct3}. The result and zero flag appear one cycle after in_valid.
module alu_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             out_valid
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    // Handshake: in_valid qualifies a/b/op at a rising edge; out_valid is high for exactly
    // the cycle after such an edge. There is no ready: every valid input is accepted.

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Shared adder: ADD uses a + b; SUB and both compares use a + ~b + 1.
    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             lt_signed;
    logic             lt_unsigned;

    assign sub_mode    = (op != OP_ADD);
    assign b_eff       = sub_mode ? ~b : b;
    assign sum_ext     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    assign sum         = sum_ext[WIDTH-1:0];
    assign carry_out   = sum_ext[WIDTH];
    assign lt_unsigned = ~carry_out;
    // Differing signs decide directly; equal signs cannot overflow, so the difference sign decides.
    assign lt_signed   = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1];

    // One logarithmic right shifter; left shifts run through it on bit-reversed data.
    logic             sh_left;
    logic             sh_fill;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] sh_in;
    logic [WIDTH-1:0] sh_right;
    logic [WIDTH-1:0] sh_stage [SHW+1];

    assign sh_left  = (op == OP_SLL);
    assign sh_fill  = (op == OP_SRA) & a[WIDTH-1];
    assign sh_amt   = b[SHW-1:0];
    assign sh_in    = sh_left ? bit_rev(a) : a;
    assign sh_stage[0] = sh_in;

    for (genvar k = 0; k < SHW; k++) begin : g_shift
        localparam int S = 1 << k;
        assign sh_stage[k+1] = sh_amt[k] ? {{S{sh_fill}}, sh_stage[k][WIDTH-1:S]} : sh_stage[k];
    end

    assign sh_right = sh_stage[SHW];

    logic [WIDTH-1:0] next_out;

    always_comb begin
        next_out = '0;
        case (op)
            OP_ADD:  next_out = sum;
            OP_SUB:  next_out = sum;
            OP_SLL:  next_out = bit_rev(sh_right);
            OP_SLT:  next_out = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU: next_out = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OP_XOR:  next_out = a ^ b;
            OP_SRL:  next_out = sh_right;
            OP_SRA:  next_out = sh_right;
            OP_OR:   next_out = a | b;
            OP_AND:  next_out = a & b;
            default: next_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out  <= next_out;
                zero <= (next_out == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model.
module tb_alu_unit;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] out;
    logic         zero;
    logic         out_valid;

    int checks   = 0;
    int failures = 0;

    alu_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .out       (out),
        .zero      (zero),
        .out_valid (out_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [3:0] code);
        int sh;
        sh = int'(y[5:0]);
        case (code)
            4'b0000: return x + y;
            4'b1000: return x - y;
            4'b0001: return x << sh;
            4'b0010: return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            4'b0011: return (x < y) ? 64'd1 : 64'd0;
            4'b0100: return x ^ y;
            4'b0101: return x >> sh;
            4'b1101: return W'($signed(x) >>> sh);
            4'b0110: return x | y;
            4'b0111: return x & y;
            default: return 64'd0;
        endcase
    endfunction

    logic [W-1:0] m_out;
    logic         m_zero;
    logic         m_valid;
    logic [W-1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out   = '0;
            m_zero  = 1'b1;
            m_valid = 1'b0;
            exp_q.delete();
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                m_out  = ref_alu(a, b, op);
                m_zero = (m_out == 0);
                exp_q.push_back(m_out);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            checks++;
            if (out_valid !== m_valid || out !== m_out || zero !== m_zero) begin
                failures++;
                $display("FAIL cycle_cmp: got out=%h zero=%b valid=%b, want out=%h zero=%b valid=%b",
                         out, zero, out_valid, m_out, m_zero, m_valid);
            end
            if (m_valid && exp_q.size() > 0) begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                checks++;
                if (out !== e) begin
                    failures++;
                    $display("FAIL queue_cmp: got out=%h, want %h", out, e);
                end
            end
        end
    end

    // ---------------- driver / literal checks ----------------
    task automatic expect_lit(input string name, input logic [W-1:0] eo, input logic ez,
                              input logic ev);
        checks++;
        if (out !== eo || zero !== ez || out_valid !== ev) begin
            failures++;
            $display("FAIL %s: got out=%h zero=%b valid=%b, want out=%h zero=%b valid=%b",
                     name, out, zero, out_valid, eo, ez, ev);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [3:0] code, input logic [W-1:0] eo, input logic ez);
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        op = code;
        @(posedge clk);
        #2;
        expect_lit(name, eo, ez, 1'b1);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return {W{1'b1}};
            2: return 64'h8000_0000_0000_0000;
            3: return 64'(($urandom_range(0, 70)));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        repeat (3) @(posedge clk);
        #2;
        expect_lit("reset", 64'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        expect_lit("post_reset_idle", 64'd0, 1'b1, 1'b0);

        run_op("add_0_0", 64'd0, 64'd0, 4'b0000, 64'd0, 1'b1);
        run_op("add_1_2", 64'd1, 64'd2, 4'b0000, 64'd3, 1'b0);
        run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 64'd0, 1'b1);
        run_op("sub_eq", 64'd2, 64'd2, 4'b1000, 64'd0, 1'b1);
        run_op("sub_neg", 64'd4, 64'd5, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("sub_pos", 64'd5, 64'd4, 4'b1000, 64'd1, 1'b0);
        run_op("and_0", 64'd1, 64'd2, 4'b0111, 64'd0, 1'b1);
        run_op("and_2", 64'd2, 64'd2, 4'b0111, 64'd2, 1'b0);
        run_op("or_1", 64'd1, 64'd1, 4'b0110, 64'd1, 1'b0);
        run_op("or_3", 64'd1, 64'd2, 4'b0110, 64'd3, 1'b0);
        run_op("xor", 64'hF0F0, 64'h0FF0, 4'b0100, 64'hFF00, 1'b0);
        run_op("srl", 64'h8000_0000_0000_0000, 64'h41, 4'b0101, 64'h4000_0000_0000_0000, 1'b0);
        run_op("sra", 64'h8000_0000_0000_0000, 64'h41, 4'b1101, 64'hC000_0000_0000_0000, 1'b0);
        run_op("sll_63", 64'd1, 64'd63, 4'b0001, 64'h8000_0000_0000_0000, 1'b0);
        run_op("sltu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0011, 64'd0, 1'b1);
        run_op("slt", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd1, 1'b0);

        // Inputs change while in_valid is low: outputs must hold the SLT result.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            op = 4'($urandom_range(0, 15));
            @(posedge clk);
            #2;
            expect_lit("hold", 64'd1, 1'b0, 1'b0);
        end

        run_op("undef_op", 64'd7, 64'd9, 4'b1111, 64'd0, 1'b1);

        // Randomized traffic; the per-cycle compare checks every cycle.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            a = rand_operand();
            b = rand_operand();
            op = 4'($urandom_range(0, 15));
        end

        // Reset asserted mid-stream discards the pending result at once.
        @(negedge clk);
        in_valid = 1'b1;
        a = 64'd10;
        b = 64'd20;
        op = 4'b0000;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        expect_lit("mid_reset", 64'd0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        expect_lit("after_mid_reset", 64'd0, 1'b1, 1'b0);
        run_op("add_after_reset", 64'd10, 64'd20, 4'b0000, 64'd30, 1'b0);

        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
